// File: rtl/controlador_es_if.sv
// Processor-side handshake of the IN/OUT controller: requests, commit pulse, data and stall/ack.
interface controlador_es_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_in;
    logic                  req_out;
    logic                  proc_passo;
    logic [DATA_WIDTH-1:0] dado_out;
    logic [DATA_WIDTH-1:0] dado_in;
    logic                  congela;
    logic                  ack;

    modport master (
        output req_in, req_out, proc_passo, dado_out,
        input  dado_in, congela, ack
    );

    modport slave (
        input  req_in, req_out, proc_passo, dado_out,
        output dado_in, congela, ack
    );
endinterface

// File: rtl/controlador_es.sv
// IN/OUT controller: stalls the core, debounces the operator button, latches switches and
// converts OUT values to BCD. Define CONTROLADOR_ES_SINAL_EN for two's-complement handling.
module controlador_es #(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 8,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clock_fpga,
    input  logic                    reset,
    input  logic                    botao,
    input  logic [SW_WIDTH-1:0]     switches,
    controlador_es_if.slave         cpu,
    output logic [4*NUM_DIGITS-1:0] bcd_digits,
    output logic                    negativo,
    output logic                    overflow
);
    // Enough digits to hold 2**DATA_WIDTH-1 (floor(DW*log10(2))+1).
    localparam int BCD_DIGITS = (DATA_WIDTH * 30103) / 100000 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {OCIOSO, ESPERA_IN, CONVERTE, ESPERA_OUT, LIBERA} estado_t;

    estado_t                 estado, estado_n;
    logic                    sinc1, sinc2, nivel, pressao;
    logic [CNT_W-1:0]        cnt_deb;
    logic [DATA_WIDTH-1:0]   bin;
    logic [BCD_W-1:0]        bcd, bcd_aj;
    logic [BIT_W-1:0]        cnt_bit;
    logic                    sinal;
    logic                    carrega_in, carrega_out, conclui, aceita, ovf_c;
    logic [DATA_WIDTH-1:0]   magnitude, sw_ext;
    logic                    sinal_c;

`ifdef CONTROLADOR_ES_SINAL_EN
    assign sinal_c   = cpu.dado_out[DATA_WIDTH-1];
    assign magnitude = sinal_c ? (~cpu.dado_out + DATA_WIDTH'(1)) : cpu.dado_out;
    assign sw_ext    = DATA_WIDTH'($signed(switches));
`else
    assign sinal_c   = 1'b0;
    assign magnitude = cpu.dado_out;
    assign sw_ext    = DATA_WIDTH'(switches);
`endif

    // Button: synchroniser, then accept a new level after DEBOUNCE_CYCLES equal samples.
    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            sinc1   <= 1'b1;
            sinc2   <= 1'b1;
            nivel   <= 1'b1;
            cnt_deb <= '0;
            pressao <= 1'b0;
        end else begin
            sinc1   <= botao;
            sinc2   <= sinc1;
            pressao <= 1'b0;
            if (sinc2 == nivel) begin
                cnt_deb <= '0;
            end else if (cnt_deb == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                nivel   <= sinc2;
                cnt_deb <= '0;
                pressao <= ~sinc2;
            end else begin
                cnt_deb <= cnt_deb + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_n;
    end

    always_comb begin
        estado_n    = estado;
        carrega_in  = 1'b0;
        carrega_out = 1'b0;
        conclui     = 1'b0;
        aceita      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (cpu.req_in) begin
                    estado_n = ESPERA_IN;
                end else if (cpu.req_out) begin
                    estado_n    = CONVERTE;
                    carrega_out = 1'b1;
                end
            end
            ESPERA_IN: begin
                if (pressao) begin
                    estado_n   = LIBERA;
                    carrega_in = 1'b1;
                    aceita     = 1'b1;
                end
            end
            CONVERTE: begin
                if (cnt_bit == BIT_W'(DATA_WIDTH)) begin
                    estado_n = ESPERA_OUT;
                    conclui  = 1'b1;
                end
            end
            ESPERA_OUT: begin
                if (pressao) begin
                    estado_n = LIBERA;
                    aceita   = 1'b1;
                end
            end
            LIBERA: begin
                if (cpu.proc_passo) estado_n = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase
    end

    // Stall is combinational so it bites in the request cycle; forced low while in reset.
    always_comb begin
        cpu.congela = ~reset & (((estado == OCIOSO) & (cpu.req_in | cpu.req_out)) |
                                (estado == ESPERA_IN) | (estado == CONVERTE) |
                                (estado == ESPERA_OUT));
    end

    always_comb begin
        bcd_aj = bcd;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        ovf_c = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            ovf_c = ovf_c | (|bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            cpu.dado_in <= '0;
            cpu.ack     <= 1'b0;
            bin         <= '0;
            bcd         <= '0;
            cnt_bit     <= '0;
            sinal       <= 1'b0;
            bcd_digits  <= '0;
            negativo    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            cpu.ack <= aceita;
            if (carrega_in) cpu.dado_in <= sw_ext;
            if (carrega_out) begin
                bin     <= magnitude;
                bcd     <= '0;
                cnt_bit <= '0;
                sinal   <= sinal_c;
            end else if ((estado == CONVERTE) && !conclui) begin
                {bcd, bin} <= {bcd_aj, bin} << 1;
                cnt_bit    <= cnt_bit + 1'b1;
            end
            if (conclui) begin
                bcd_digits <= bcd[4*NUM_DIGITS-1:0];
                overflow   <= ovf_c;
                negativo   <= sinal;
            end
        end
    end
endmodule

// File: tb/tb_controlador_es.sv
// Self-checking bench for controlador_es: table-driven OUT conversions plus IN, bounce and reset sequences.
module tb_controlador_es;
    localparam int DW = 32, SW = 8, ND = 4, DEB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          botao = 1'b1;
    logic [SW-1:0] switches = '0;
    logic [4*ND-1:0] bcd;
    logic          neg, ovf;

    controlador_es_if #(.DATA_WIDTH(DW)) cpu ();

    controlador_es #(
        .DATA_WIDTH(DW), .SW_WIDTH(SW), .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock_fpga(clk), .reset(rst), .botao(botao), .switches(switches),
        .cpu(cpu), .bcd_digits(bcd), .negativo(neg), .overflow(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t        tab [8];
    vec_t        sb [$];
    vec_t        e;
    int          n_vec = 0, n_err = 0;
    int          ack_cnt = 0;
    logic        cong_at_ack = 1'b1;
    int          a0;
    logic [15:0] prev_bcd;
    logic [31:0] exp_in;

    always @(negedge clk) begin
        if (cpu.ack) begin
            ack_cnt++;
            cong_at_ack = cpu.congela;
        end
    end

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nome, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input int n);
        botao = 1'b0;
        tick(n);
        botao = 1'b1;
        tick(DEB + 4);
    endtask

    task automatic proc_step();
        cpu.req_in     = 1'b0;
        cpu.req_out    = 1'b0;
        cpu.proc_passo = 1'b1;
        tick(1);
        cpu.proc_passo = 1'b0;
        tick(1);
    endtask

    initial begin
        tab[0] = '{32'd1234,  16'h1234, 1'b0, 1'b0};
        tab[1] = '{32'd12345, 16'h2345, 1'b0, 1'b1};
        tab[2] = '{32'd0,     16'h0000, 1'b0, 1'b0};
        tab[3] = '{32'd9999,  16'h9999, 1'b0, 1'b0};
        tab[4] = '{32'd10000, 16'h0000, 1'b0, 1'b1};
`ifdef CONTROLADOR_ES_SINAL_EN
        tab[5] = '{32'hFFFF_FFF9, 16'h0007, 1'b1, 1'b0};
        tab[6] = '{32'h8000_0000, 16'h3648, 1'b1, 1'b1};
        tab[7] = '{32'hFFFF_FFFF, 16'h0001, 1'b1, 1'b0};
`else
        tab[5] = '{32'hFFFF_FFFF, 16'h7295, 1'b0, 1'b1};
        tab[6] = '{32'h8000_0000, 16'h3648, 1'b0, 1'b1};
        tab[7] = '{32'd7,         16'h0007, 1'b0, 1'b0};
`endif
        cpu.req_in = 1'b1; cpu.req_out = 1'b0; cpu.proc_passo = 1'b0; cpu.dado_out = '0;
        switches = 8'hA5;

        // Reset with req_in held high
        tick(3);
        chk("reset_congela", cpu.congela, 0);
        chk("reset_dado_in", cpu.dado_in, 0);
        chk("reset_ack", cpu.ack, 0);
        chk("reset_bcd", {bcd, neg, ovf}, 0);
        rst = 1'b0;
        #1;
        chk("congela_request_cycle", cpu.congela, 1);
        tick(1);
        chk("congela_espera_in", cpu.congela, 1);

        // IN transaction
`ifdef CONTROLADOR_ES_SINAL_EN
        exp_in = 32'hFFFF_FFA5;
`else
        exp_in = 32'h0000_00A5;
`endif
        a0 = ack_cnt;
        press(8);
        chk("in_ack_pulses", ack_cnt - a0, 1);
        chk("in_congela_at_ack", cong_at_ack, 0);
        chk("in_dado_in", cpu.dado_in, exp_in);
        chk("libera_congela", cpu.congela, 0);
        tick(3);
        chk("libera_ignores_req", cpu.congela, 0);
        proc_step();
        chk("ocioso_after_passo", cpu.congela, 0);

        // Bounce shorter than the debounce window
        cpu.req_in = 1'b1;
        switches   = 8'h3C;
        tick(1);
        a0    = ack_cnt;
        botao = 1'b0;
        tick(3);
        botao = 1'b1;
        tick(12);
        chk("bounce_no_ack", ack_cnt - a0, 0);
        chk("bounce_congela", cpu.congela, 1);
        press(8);
        chk("bounce_then_press_ack", ack_cnt - a0, 1);
        chk("bounce_dado_in", cpu.dado_in, 32'h0000_003C);
        proc_step();

        // OUT conversions from the table, with exact latency check
        prev_bcd = '0;
        for (int i = 0; i < 8; i++) begin
            a0 = ack_cnt;
            cpu.dado_out = tab[i].v;
            cpu.req_out  = 1'b1;
            sb.push_back(tab[i]);
            tick(1);
            cpu.req_out = 1'b0;
            chk("out_congela", cpu.congela, 1);
            tick(32);
            chk($sformatf("out%0d_not_early", i), bcd, prev_bcd);
            tick(1);
            chk($sformatf("out%0d_latency", i), bcd, tab[i].bcd);
            chk($sformatf("out%0d_wait_press", i), {cpu.congela, 8'(ack_cnt - a0)}, {1'b1, 8'd0});
            press(8);
            chk($sformatf("out%0d_ack", i), ack_cnt - a0, 1);
            chk($sformatf("out%0d_congela_at_ack", i), cong_at_ack, 0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("out%0d_bcd", i), bcd, e.bcd);
                chk($sformatf("out%0d_neg", i), neg, e.neg);
                chk($sformatf("out%0d_ovf", i), ovf, e.ovf);
            end
            proc_step();
            prev_bcd = tab[i].bcd;
        end

        // Press during CONVERTE is discarded
        a0 = ack_cnt;
        cpu.dado_out = 32'd4321;
        cpu.req_out  = 1'b1;
        tick(1);
        cpu.req_out = 1'b0;
        press(8);
        tick(30);
        chk("conv_press_discarded", ack_cnt - a0, 0);
        chk("conv_press_congela", cpu.congela, 1);
        chk("conv_press_bcd", bcd, 16'h4321);
        press(8);
        chk("conv_fresh_press_ack", ack_cnt - a0, 1);
        proc_step();

        // Both requests: IN wins, display untouched
`ifdef CONTROLADOR_ES_SINAL_EN
        exp_in = 32'hFFFF_FF81;
`else
        exp_in = 32'h0000_0081;
`endif
        a0 = ack_cnt;
        cpu.dado_out = 32'd777;
        switches     = 8'h81;
        cpu.req_in   = 1'b1;
        cpu.req_out  = 1'b1;
        tick(1);
        cpu.req_out = 1'b0;
        tick(40);
        chk("both_display_unchanged", bcd, 16'h4321);
        press(8);
        chk("both_ack", ack_cnt - a0, 1);
        chk("both_dado_in", cpu.dado_in, exp_in);
        chk("both_display_after", bcd, 16'h4321);
        proc_step();

        // Reset in the middle of a conversion
        a0 = ack_cnt;
        cpu.dado_out = 32'd55;
        cpu.req_out  = 1'b1;
        tick(1);
        cpu.req_out = 1'b0;
        tick(10);
        rst = 1'b1;
        #1;
        chk("midreset_congela", cpu.congela, 0);
        tick(1);
        chk("midreset_outputs", {cpu.dado_in, bcd, neg, ovf, cpu.ack}, 0);
        rst = 1'b0;
        tick(40);
        chk("midreset_idle", cpu.congela, 0);
        press(8);
        chk("midreset_no_ack", ack_cnt - a0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/controlador_es.md
# controlador_es

Parametrised I/O controller for the MIPS-style processor: it services the IN and OUT instructions, replacing the fixed switch-input/freeze/display path with one sequenced unit. It stalls the core, waits for a debounced operator button press, latches the switch value for IN, and converts OUT values to BCD digits for the 7-segment decoders. It sits between the control unit and register file on one side, and the board switches, button and BCD decoders on the other.

## Interface
- DATA_WIDTH, 32, processor data width.
- SW_WIDTH, 8, number of board switches; must be ≤ DATA_WIDTH.
- NUM_DIGITS, 4, number of displayed decimal digits, 1..10.
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a button level; ≥ 2.

Ports:
- clock_fpga  in  1  board clock; every register here uses it.
- reset  in  1  asynchronous, active-high.
- botao  in  1  raw push-button, active-low (0 = pressed), asynchronous to clock_fpga.
- switches  in  SW_WIDTH  raw switch bank.
- req_in  in  1  control unit is executing IN (level).
- req_out  in  1  control unit is executing OUT (level).
- proc_passo  in  1  one-cycle pulse when the processor commits an instruction.
- dado_out  in  DATA_WIDTH  value to display (register rs).
- dado_in  out  DATA_WIDTH  latched switch value for the register file.
- congela  out  1  processor stall.
- ack  out  1  one-cycle pulse when an IN/OUT transaction completes.
- bcd_digits  out  4*NUM_DIGITS  BCD digits; digit 0 (units) in bits [3:0].
- negativo  out  1  displayed value is negative.
- overflow  out  1  |value| ≥ 10^NUM_DIGITS.

## Operation
- Button path: 2-flop synchroniser, then a counter that accepts a new debounced level after DEBOUNCE_CYCLES equal consecutive samples. A "press" is a debounced 1→0 transition. Presses are consumed only in ESPERA_IN and ESPERA_OUT; elsewhere they are discarded and never queued.
- FSM states:
  - OCIOSO: req_in → ESPERA_IN. req_out → CONVERTE, loading |dado_out| and the sign. If both requests are high, req_in has priority.
  - ESPERA_IN: on press, dado_in ← extended switches (see Configuration), pulse ack, → LIBERA.
  - CONVERTE: shift-add-3 (double dabble), one bit per cycle, for DATA_WIDTH cycles, then → ESPERA_OUT. The display registers update on that transition.
  - ESPERA_OUT: on press, pulse ack, → LIBERA.
  - LIBERA: wait for proc_passo → OCIOSO. This guarantees that back-to-back IN/OUT instructions are each serviced separately.
- congela = (OCIOSO and (req_in or req_out)) or state ∈ {ESPERA_IN, CONVERTE, ESPERA_OUT}. It is combinational, so the stall takes effect in the request cycle. congela is 0 in LIBERA.
- Conversion: the internal BCD width covers every DATA_WIDTH value. bcd_digits holds the low NUM_DIGITS digits; overflow = any higher digit is nonzero.
- bcd_digits, negativo and overflow hold until the next completed conversion. dado_in holds until the next IN.

## Timing
- Reset values: all outputs 0, FSM in OCIOSO, debounced level = released, debounce counter 0.
- A reset asserted mid-transaction aborts it immediately; no ack is issued.
- OUT latency: req_out sampled at edge t → display valid after edge t+DATA_WIDTH+1.
- IN latency: ack rises at the edge after the press is accepted. dado_in updates at the same edge.
- ack is high for exactly one cycle per transaction. congela falls in the same cycle ack is high.
- Press acceptance: the press is accepted DEBOUNCE_CYCLES+2 cycles after a clean low on botao (2 for the synchroniser).
- req_in/req_out are ignored outside OCIOSO.

## Configuration
- CONTROLADOR_ES_SINAL_EN defined:
  - dado_out is two's complement; the magnitude is converted and negativo = sign bit.
  - dado_in = switches sign-extended from bit SW_WIDTH-1.
  - The most negative value converts correctly (unsigned magnitude).
- Not defined:
  - dado_out is unsigned; negativo tied to 0.
  - dado_in is zero-extended.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and default widths.
- Reset with req_in=1 → all outputs 0; after release, congela=1 in the same cycle.
- IN: switches=8'hA5, req_in=1, hold botao=0 for 8 cycles → dado_in=0x000000A5 (unsigned) / 0xFFFFFFA5 (signed), one ack pulse, congela=0. Held in LIBERA until proc_passo.
- OUT: dado_out=1234, req_out=1 → bcd_digits=16'h1234 after 33 edges, overflow=0; congela stays 1 until press, then ack.
- OUT 12345 → bcd_digits=16'h2345, overflow=1. With SINAL_EN, dado_out=-7 → 16'h0007, negativo=1.
- Bounce: botao low for 3 cycles in ESPERA_IN → no ack, congela stays 1. A press during CONVERTE is discarded; a fresh press is still required in ESPERA_OUT.
- req_in and req_out high together → ESPERA_IN entered, display unchanged; reset in CONVERTE → OCIOSO, no ack.
